dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- MEM-stage initiator for the word-addressed data memory, which has asynchronous read and synchronous write.
- Converts CPU load/store requests (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into word-granular memory reads and writes.
- Sub-word stores use a two-cycle read-modify-write sequence.
- Loads are byte/half-extracted, sign- or zero-extended, and registered.
- Misaligned or illegal accesses are flagged and never touch memory.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result, extended; 0 for stores and errors
- resp_err  output  1  valid with resp_valid; misaligned or illegal request
- mem_addr  output  32  byte address to memory, always word-aligned ({addr[31:2],2'b00})
- mem_din  output  32  write data to memory
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable (memory commits at the clk edge)
- mem_dout  input  32  asynchronous read data from memory

Behaviour:
- States: IDLE, RMW_WR. req_ready = (state==IDLE). A request is accepted when req_valid && req_ready.
- Reset (async): state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0; all latched address/data registers 0.
- Memory outputs are combinational from state and request. With no access: mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
- Legality:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - funct3 011/110/111 is illegal.
  - A store with funct3 100 or 101 is illegal.
  - Illegal accept: no mem_read/mem_write. Next cycle resp_valid=1, resp_err=1, resp_rdata=0. State stays IDLE.
- Load (IDLE):
  - mem_read=1, mem_addr aligned.
  - At the edge, the byte lane at addr[1:0] (bits 8*off+7:8*off, little-endian) or the half lane at addr[1] is extracted from mem_dout and extended.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Result is registered into resp_rdata. resp_valid=1 the next cycle. Latency 1, throughput 1 per cycle.
- Store W (IDLE): mem_write=1, mem_din=req_wdata, mem_addr aligned. resp_valid=1 next cycle, resp_rdata=0.
- Store B/H:
  - Cycle A (IDLE): mem_read=1, mem_addr aligned. Latch the merged word at the edge: mem_dout with the selected lane replaced by req_wdata[7:0] or req_wdata[15:0]. Latch the aligned address. Go to RMW_WR.
  - Cycle B (RMW_WR): req_ready=0; mem_write=1, mem_addr=latched, mem_din=merged. Return to IDLE. resp_valid=1 the following cycle.
  - Only the targeted bytes change; the other bytes keep their prior value.
- resp_valid is a single-cycle pulse per request. Back-to-back requests give back-to-back pulses.
- mem_read and mem_write are never both 1.
- req_* inputs are ignored in RMW_WR; the CPU must hold them until req_ready.
- Reset asserted in RMW_WR: state→IDLE and mem_write drops immediately, so no write occurs. Any pending resp_valid is cleared.
- No internal error state: after an error response the next request is accepted normally.

Test Plan:
- Preload mem word @0x100 = 0x8899AABB. Issue LW 0x100 → mem_read=1, mem_addr=0x100; next cycle resp_valid=1, resp_rdata=0x8899AABB, resp_err=0.
- Same word. LB 0x103 → resp_rdata=0xFFFFFF88. LBU 0x103 → 0x00000088. LH 0x102 → 0xFFFF8899. LHU 0x100 → 0x0000AABB.
- SB 0x101, wdata 0x12345677:
  - cycle A: mem_read=1;
  - cycle B: req_ready=0, mem_write=1, mem_din=0x889977BB;
  - next cycle: resp_valid=1.
  - Then LW 0x100 → 0x889977BB.
- SH 0x101 or LW 0x102 or funct3=011 → no mem_read/mem_write asserted; resp_valid=1, resp_err=1, resp_rdata=0. Memory word unchanged.
- Assert reset during RMW_WR of SH 0x100 → mem_write deasserts immediately, req_ready=1, no resp_valid. Word @0x100 unchanged.
- Issue SW 0x200 (0xDEADBEEF) then LW 0x200 on consecutive cycles → two consecutive resp_valid pulses; the second has resp_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage initiator for a word-addressed data memory with
// asynchronous read and synchronous write. Loads complete in one cycle with a
// registered, extended result; full-word stores write directly; byte and half
// stores use a read-modify-write pair (read/merge, then write). Misaligned or
// illegal requests are answered with an error and never touch memory.
module dmem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] rmw_addr_q, rmw_addr_d;
    logic [31:0] rmw_data_q, rmw_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept_s;
    logic        illegal_s;
    logic [31:0] aligned_addr_s;

    // Select the addressed byte/half lane and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'h000000, b};
            F3_HU:   r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half lane of a word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (f3)
            F3_B: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = word;
                endcase
            end
            F3_H: begin
                if (off[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_ready      = (state_q == IDLE);
    assign accept_s       = req_valid && (state_q == IDLE);
    assign aligned_addr_s = {req_addr[31:2], 2'b00};

    // Legality decode: unknown sizes, unsigned stores and misalignment are errors.
    always_comb begin
        illegal_s = 1'b0;
        case (req_funct3)
            F3_B:         illegal_s = 1'b0;
            F3_H:         illegal_s = req_addr[0];
            F3_W:         illegal_s = (req_addr[1:0] != 2'b00);
            F3_BU:        illegal_s = req_write;
            F3_HU:        illegal_s = req_write || req_addr[0];
            default:      illegal_s = 1'b1;
        endcase
    end

    // Memory-side drive, next state, RMW latches and response next-values.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = 32'h0000_0000;
        mem_din      = 32'h0000_0000;
        state_d      = state_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_data_d   = rmw_data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        case (state_q)
            RMW_WR: begin
                // Second half of a sub-word store: commit the merged word.
                mem_write    = 1'b1;
                mem_addr     = rmw_addr_q;
                mem_din      = rmw_data_q;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            IDLE: begin
                if (accept_s) begin
                    if (illegal_s) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_write) begin
                        mem_read     = 1'b1;
                        mem_addr     = aligned_addr_s;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_extract(mem_dout, req_funct3, req_addr[1:0]);
                    end else if (req_funct3 == F3_W) begin
                        mem_write    = 1'b1;
                        mem_addr     = aligned_addr_s;
                        mem_din      = req_wdata;
                        resp_valid_d = 1'b1;
                    end else begin
                        // First half of a sub-word store: read and merge.
                        mem_read   = 1'b1;
                        mem_addr   = aligned_addr_s;
                        rmw_addr_d = aligned_addr_s;
                        rmw_data_d = store_merge(mem_dout, req_funct3, req_addr[1:0], req_wdata);
                        state_d    = RMW_WR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, RMW latches and registered response; reset abandons any pending RMW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rmw_addr_q   <= 32'h0000_0000;
            rmw_data_q   <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_data_q   <= rmw_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural async-read /
// sync-write memory. Inputs change 1 time unit after a rising edge.
module tb_dmem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];

    int checks;
    int failures;

    dmem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous read port of the behavioural memory.
    assign mem_dout = mem[mem_addr[11:2]];

    // Synchronous write port of the behavioural memory.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[11:2]] <= mem_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h8899AABB;

        step();
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_mem_rw",     {30'h0, mem_read, mem_write}, 32'h0);
        reset = 1'b0;

        // LW 0x100
        req(1'b0, 3'b010, 32'h100, 32'h0);
        #2;
        chk("lw_mem_read", {31'h0, mem_read}, 32'h1);
        chk("lw_mem_addr", mem_addr, 32'h100);
        chk("lw_mem_write", {31'h0, mem_write}, 32'h0);
        step();
        chk("lw_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("lw_rdata", resp_rdata, 32'h8899AABB);
        chk("lw_err", {31'h0, resp_err}, 32'h0);

        // Back-to-back sub-word loads
        req(1'b0, 3'b000, 32'h103, 32'h0);
        #2 chk("lb_mem_addr", mem_addr, 32'h100);
        step();
        chk("lb_valid", {31'h0, resp_valid}, 32'h1);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF88);
        req(1'b0, 3'b100, 32'h103, 32'h0);
        step();
        chk("lbu_rdata", resp_rdata, 32'h00000088);
        req(1'b0, 3'b001, 32'h102, 32'h0);
        step();
        chk("lh_rdata", resp_rdata, 32'hFFFF8899);
        req(1'b0, 3'b101, 32'h100, 32'h0);
        step();
        chk("lhu_valid", {31'h0, resp_valid}, 32'h1);
        chk("lhu_rdata", resp_rdata, 32'h0000AABB);
        req_valid = 1'b0;
        step();
        chk("pulse_end", {31'h0, resp_valid}, 32'h0);

        // SB 0x101 read-modify-write
        req(1'b1, 3'b000, 32'h101, 32'h12345677);
        #2;
        chk("sb_a_mem_read", {31'h0, mem_read}, 32'h1);
        chk("sb_a_mem_write", {31'h0, mem_write}, 32'h0);
        chk("sb_a_mem_addr", mem_addr, 32'h100);
        step();
        chk("sb_b_ready", {31'h0, req_ready}, 32'h0);
        chk("sb_b_mem_write", {31'h0, mem_write}, 32'h1);
        chk("sb_b_mem_read", {31'h0, mem_read}, 32'h0);
        chk("sb_b_mem_din", mem_din, 32'h889977BB);
        chk("sb_b_mem_addr", mem_addr, 32'h100);
        chk("sb_b_no_resp", {31'h0, resp_valid}, 32'h0);
        step();
        chk("sb_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("sb_resp_rdata", resp_rdata, 32'h0);
        chk("sb_mem_word", mem[32'h100 >> 2], 32'h889977BB);
        req(1'b0, 3'b010, 32'h100, 32'h0);
        step();
        chk("sb_lw_rdata", resp_rdata, 32'h889977BB);

        // Illegal requests: SH 0x101, LW 0x102, funct3 011, store funct3 100
        req(1'b1, 3'b001, 32'h101, 32'hFFFFFFFF);
        #2 chk("sh_mis_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        step();
        chk("sh_mis_valid", {31'h0, resp_valid}, 32'h1);
        chk("sh_mis_err", {31'h0, resp_err}, 32'h1);
        chk("sh_mis_rdata", resp_rdata, 32'h0);
        req(1'b0, 3'b010, 32'h102, 32'h0);
        #2 chk("lw_mis_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        step();
        chk("lw_mis_err", {31'h0, resp_err}, 32'h1);
        chk("lw_mis_rdata", resp_rdata, 32'h0);
        req(1'b0, 3'b011, 32'h100, 32'h0);
        #2 chk("f3_011_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        step();
        chk("f3_011_err", {31'h0, resp_err}, 32'h1);
        chk("f3_011_valid", {31'h0, resp_valid}, 32'h1);
        req(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);
        #2 chk("sbu_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        step();
        chk("sbu_err", {31'h0, resp_err}, 32'h1);
        chk("err_mem_word", mem[32'h100 >> 2], 32'h889977BB);
        // Normal acceptance after an error
        req(1'b0, 3'b010, 32'h100, 32'h0);
        step();
        chk("after_err_err", {31'h0, resp_err}, 32'h0);
        chk("after_err_rdata", resp_rdata, 32'h889977BB);
        req_valid = 1'b0;
        step();

        // Reset during RMW_WR of SH 0x100
        req(1'b1, 3'b001, 32'h100, 32'h0000CAFE);
        step();
        chk("rst_rmw_pre_write", {31'h0, mem_write}, 32'h1);
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_rmw_write", {31'h0, mem_write}, 32'h0);
        chk("rst_rmw_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rmw_valid", {31'h0, resp_valid}, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("rst_rmw_no_resp", {31'h0, resp_valid}, 32'h0);
        chk("rst_rmw_mem_word", mem[32'h100 >> 2], 32'h889977BB);

        // SW 0x200 then LW 0x200 back to back
        req(1'b1, 3'b010, 32'h200, 32'hDEADBEEF);
        #2;
        chk("sw_mem_write", {31'h0, mem_write}, 32'h1);
        chk("sw_mem_din", mem_din, 32'hDEADBEEF);
        chk("sw_mem_addr", mem_addr, 32'h200);
        step();
        chk("sw_valid", {31'h0, resp_valid}, 32'h1);
        chk("sw_rdata", resp_rdata, 32'h0);
        req(1'b0, 3'b010, 32'h200, 32'h0);
        step();
        chk("lw2_valid", {31'h0, resp_valid}, 32'h1);
        chk("lw2_rdata", resp_rdata, 32'hDEADBEEF);

        // SH 0x202 upper half merge, then LH 0x202
        req(1'b1, 3'b001, 32'h202, 32'hFFFF1234);
        step();
        chk("sh_hi_mem_din", mem_din, 32'h1234BEEF);
        step();
        chk("sh_hi_valid", {31'h0, resp_valid}, 32'h1);
        req(1'b0, 3'b001, 32'h202, 32'h0);
        step();
        chk("sh_hi_lh", resp_rdata, 32'h00001234);
        req_valid = 1'b0;
        step();
        chk("final_idle", {31'h0, resp_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
